// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream (in_*) and downstream (out_*) sides.
// The stage itself uses the slave modport and the traffic source/sink uses master.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage with halt, flush and a saturating backpressure counter.
// in_ready is driven only from registered state, which breaks the ready path between stages.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_sys,
    input  logic             flush,
    pipe_stage_skid_if.slave bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] main_reg, main_next;
    logic [DATA_W-1:0] skid_reg, skid_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic in_ready_int;
    logic out_valid_int;
    logic in_xfer;
    logic out_xfer;

    // Gating with rst keeps in_ready low for the whole time reset is held.
    assign in_ready_int  = rst && (state_reg != FULL) && !halt_sys;
    assign out_valid_int = (state_reg != EMPTY) && !halt_sys;
    assign in_xfer       = bus.in_valid && in_ready_int;
    assign out_xfer      = out_valid_int && bus.out_ready;

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_data  = main_reg;
    assign occupancy     = state_reg;
    assign stall_cnt     = cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        cnt_next   = cnt_reg;

        // out_valid is already low under halt, so the counter freezes with the stage.
        if (out_valid_int && !bus.out_ready && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end

        if (flush) begin
            state_next = EMPTY;
        end else if (!halt_sys) begin
            case (state_reg)
                EMPTY: begin
                    if (in_xfer) begin
                        state_next = BUSY;
                        main_next  = bus.in_data;
                    end
                end
                BUSY: begin
                    case ({in_xfer, out_xfer})
                        2'b10: begin
                            state_next = FULL;
                            skid_next  = bus.in_data;
                        end
                        2'b01: state_next = EMPTY;
                        2'b11: main_next  = bus.in_data;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (out_xfer) begin
                        state_next = BUSY;
                        main_next  = skid_reg;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic against a queue model.
// A second instance with a 2-bit counter shares the same stimulus to observe saturation.
module tb_pipe_stage_skid;
    logic        clk;
    logic        rst;
    logic        halt_sys;
    logic        flush;
    logic [1:0]  occ;
    logic [1:0]  occ_s;
    logic [15:0] stall;
    logic [1:0]  stall_s;

    int errors = 0;
    int checks = 0;

    logic [31:0] mq[$];
    int unsigned mcnt;

    pipe_stage_skid_if #(.DATA_W(32)) bus ();
    pipe_stage_skid_if #(.DATA_W(32)) bus_s ();

    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.in_data   = bus.in_data;
    assign bus_s.out_ready = bus.out_ready;

    pipe_stage_skid #(.DATA_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .halt_sys  (halt_sys),
        .flush     (flush),
        .bus       (bus.slave),
        .occupancy (occ),
        .stall_cnt (stall)
    );

    pipe_stage_skid #(.DATA_W(32), .CNT_W(2)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .halt_sys  (halt_sys),
        .flush     (flush),
        .bus       (bus_s.slave),
        .occupancy (occ_s),
        .stall_cnt (stall_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a FIFO of at most two payloads, updated once per rising edge.
    task automatic model_step();
        bit ir;
        bit ov;
        ir = rst && (mq.size() < 2) && !halt_sys;
        ov = (mq.size() > 0) && !halt_sys;
        if (!rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (ov && !bus.out_ready) mcnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (ov && bus.out_ready) void'(mq.pop_front());
                if (ir && bus.in_valid) mq.push_back(bus.in_data);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        halt_sys      = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        mq.delete();
        mcnt = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occ); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (stall !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall); end
        checks++; if (bus.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
        rst = 1'b1;
        mq.delete();
        mcnt = 0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h77;
        step();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h77) begin
            errors++; $display("FAIL first_edge_accept: got valid=%b data=%h expected valid=1 data=77", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic run_stream(input string tag);
        logic [31:0] vals[3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vals[i];
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i]) begin
                errors++; $display("FAIL %s_data%0d: got valid=%b data=%h expected valid=1 data=%h", tag, i, bus.out_valid, bus.out_data, vals[i]);
            end
            checks++; if (occ !== 2'd1) begin errors++; $display("FAIL %s_occ%0d: got %0d expected 1", tag, i, occ); end
        end
        bus.in_valid = 1'b0;
        step();
        checks++; if (occ !== 2'd0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_drain: got occ=%0d valid=%b expected occ=0 valid=0", tag, occ, bus.out_valid);
        end
        checks++; if (stall !== 16'd0) begin errors++; $display("FAIL %s_stall: got %0d expected 0", tag, stall); end
    endtask

    task automatic test_stream();
        reset_dut();
        run_stream("stream");
    endtask

    task automatic test_backpressure();
        reset_dut();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA;
        step();
        checks++; if (occ !== 2'd1 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_first: got occ=%0d in_ready=%b expected occ=1 in_ready=1", occ, bus.in_ready);
        end
        bus.in_data = 32'hB;
        step();
        bus.in_data = 32'hC;
        for (int i = 0; i < 2; i++) begin
            checks++; if (occ !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 32'hA) begin
                errors++; $display("FAIL bp_full%0d: got occ=%0d in_ready=%b data=%h expected occ=2 in_ready=0 data=a", i, occ, bus.in_ready, bus.out_data);
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.out_data !== 32'hA) begin errors++; $display("FAIL bp_out_a: got %h expected a", bus.out_data); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hB || occ !== 2'd1) begin
            errors++; $display("FAIL bp_out_b: got valid=%b data=%h occ=%0d expected valid=1 data=b occ=1", bus.out_valid, bus.out_data, occ);
        end
        step();
        checks++; if (occ !== 2'd0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain: got occ=%0d valid=%b expected occ=0 valid=0 (0xC must not be taken)", occ, bus.out_valid);
        end
        checks++; if (stall !== 16'd3) begin errors++; $display("FAIL bp_stall: got %0d expected 3", stall); end
    endtask

    task automatic test_flush();
        reset_dut();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h1;
        step();
        bus.in_data = 32'h2;
        step();
        checks++; if (occ !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 2", occ); end
        bus.in_data   = 32'h5A;
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (occ !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_empty: got occ=%0d valid=%b in_ready=%b expected occ=0 valid=0 in_ready=1", occ, bus.out_valid, bus.in_ready);
        end
        checks++; if (stall !== 16'd1) begin errors++; $display("FAIL flush_stall: got %0d expected 1", stall); end
        step();
        checks++; if (occ !== 2'd0) begin errors++; $display("FAIL flush_no_accept: got occ=%0d expected 0", occ); end
    endtask

    task automatic test_halt();
        reset_dut();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h99;
        step();
        bus.in_data = 32'hEE;
        halt_sys    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL halt_hs%0d: got valid=%b in_ready=%b expected 0 0", i, bus.out_valid, bus.in_ready);
            end
            step();
            checks++; if (occ !== 2'd1 || bus.out_data !== 32'h99 || stall !== 16'd0) begin
                errors++; $display("FAIL halt_frozen%0d: got occ=%0d data=%h stall=%0d expected occ=1 data=99 stall=0", i, occ, bus.out_data, stall);
            end
        end
        halt_sys     = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h99) begin
            errors++; $display("FAIL halt_resume: got valid=%b data=%h expected valid=1 data=99", bus.out_valid, bus.out_data);
        end
        step();
        checks++; if (occ !== 2'd0) begin errors++; $display("FAIL halt_drain: got occ=%0d expected 0", occ); end
    endtask

    task automatic test_saturation();
        reset_dut();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h42;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (stall_s !== 2'd3) begin errors++; $display("FAIL sat_small: got %0d expected 3", stall_s); end
        checks++; if (stall !== 16'd6) begin errors++; $display("FAIL sat_wide: got %0d expected 6", stall); end
        checks++; if (occ_s !== 2'd1 || bus_s.out_data !== 32'h42) begin
            errors++; $display("FAIL sat_hold: got occ=%0d data=%h expected occ=1 data=42", occ_s, bus_s.out_data);
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA1;
        step();
        bus.in_data = 32'hB2;
        step();
        bus.in_valid = 1'b0;
        step();
        checks++; if (occ !== 2'd2) begin errors++; $display("FAIL arst_pre_occ: got %0d expected 2", occ); end
        #2;
        rst = 1'b0;
        mq.delete();
        mcnt = 0;
        #1;
        checks++; if (occ !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL arst_now: got occ=%0d valid=%b in_ready=%b expected 0 0 0", occ, bus.out_valid, bus.in_ready);
        end
        checks++; if (stall !== 16'd0 || bus.out_data !== 32'd0) begin
            errors++; $display("FAIL arst_regs: got stall=%0d data=%h expected 0 0", stall, bus.out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        run_stream("arst_stream");
    endtask

    task automatic test_random();
        logic [31:0] exp_data;
        bit          exp_ir;
        bit          exp_ov;
        int unsigned exp_cnt;
        int unsigned exp_cnt_s;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            halt_sys      = ($urandom_range(0, 9) == 0);
            flush         = ($urandom_range(0, 19) == 0);
            #1;
            exp_ir    = (mq.size() < 2) && !halt_sys;
            exp_ov    = (mq.size() > 0) && !halt_sys;
            exp_data  = (mq.size() > 0) ? mq[0] : 32'd0;
            exp_cnt   = (mcnt > 65535) ? 65535 : mcnt;
            exp_cnt_s = (mcnt > 3) ? 3 : mcnt;
            checks++; if (bus.in_ready !== exp_ir) begin errors++; $display("FAIL rnd_in_ready@%0d: got %b expected %b", i, bus.in_ready, exp_ir); end
            checks++; if (bus.out_valid !== exp_ov) begin errors++; $display("FAIL rnd_out_valid@%0d: got %b expected %b", i, bus.out_valid, exp_ov); end
            if (exp_ov) begin
                checks++; if (bus.out_data !== exp_data) begin errors++; $display("FAIL rnd_out_data@%0d: got %h expected %h", i, bus.out_data, exp_data); end
            end
            checks++; if (occ !== 2'(mq.size())) begin errors++; $display("FAIL rnd_occ@%0d: got %0d expected %0d", i, occ, mq.size()); end
            checks++; if (stall !== 16'(exp_cnt)) begin errors++; $display("FAIL rnd_stall@%0d: got %0d expected %0d", i, stall, exp_cnt); end
            checks++; if (stall_s !== 2'(exp_cnt_s)) begin errors++; $display("FAIL rnd_stall_small@%0d: got %0d expected %0d", i, stall_s, exp_cnt_s); end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_halt();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
